// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//   Time-multiplexed driver for an eight-digit, active-low seven-segment
//   display. Each digit is lit for SCAN_DIV clocks. New data is staged in a
//   pending register. It moves into the displayed shadow register only at the
//   7-to-0 digit wrap, so a frame never mixes old and new data.
//
// Parameters
//   SCAN_DIV  clocks each digit stays lit (must be >= 2)
//
// Ports
//   clk       system clock, rising edge
//   Rst_n     asynchronous active-low reset
//   data      value to display; nibble k drives digit k
//   load      capture data into the pending register (sampled every edge)
//   all8      lamp test: every segment and dp lit
//   blank_lz  blank digits above the highest non-zero nibble
//   dp_mask   bit k lights the decimal point of digit k
//   which     index of the active digit
//   seg       registered segments, active-low; seg[7]=dp, seg[6:0]=g..a
//   upd_ack   one-cycle pulse when pending data becomes the shadow
//   frame     one-cycle pulse on the terminal-count cycle of digit 7
// -----------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        Rst_n,
    input  logic [31:0] data,
    input  logic        load,
    input  logic        all8,
    input  logic        blank_lz,
    input  logic [7:0]  dp_mask,
    output logic [2:0]  which,
    output logic [7:0]  seg,
    output logic        upd_ack,
    output logic        frame
);

    localparam int unsigned       CNT_W   = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_which;
    logic [31:0]      r_shadow;
    logic [31:0]      r_pend;
    logic             r_pend_vld;
    logic [7:0]       r_seg;

    logic             w_tc;
    logic             w_boundary;
    logic             w_xfer;
    logic [31:0]      w_shifted;
    logic [3:0]       w_nib;
    logic             w_blank;
    logic [6:0]       w_glyph;
    logic [7:0]       w_seg_next;

    assign w_tc       = (r_cnt == CNT_MAX);
    assign w_boundary = w_tc && (r_which == 3'd7);
    assign w_xfer     = w_boundary && r_pend_vld;

    // Both pulses are decoded from registered state only, so they are clean
    // for the whole boundary cycle and line up with the edge that applies it.
    assign frame   = w_boundary;
    assign upd_ack = w_xfer;
    assign which   = r_which;
    assign seg     = r_seg;

    // Scan counter and digit index.
    // NOTE: all state uses non-blocking assignments so every register samples
    // values from before the edge; blocking here would create ordering races.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt   <= '0;
            r_which <= 3'd0;
        end else if (w_tc) begin
            r_cnt   <= '0;
            r_which <= r_which + 3'd1;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // Pending/shadow staging. A load on the boundary cycle lands in the
    // pending register; the transfer on that edge uses the old pending value.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_shadow   <= '0;
        end else begin
            if (w_xfer) begin
                r_shadow <= r_pend;
            end
            if (load) begin
                r_pend     <= data;
                r_pend_vld <= 1'b1;
            end else if (w_xfer) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    // The active digit sits in the low nibble after shifting; the digit is
    // blanked when nothing non-zero remains at or above it (digit 0 excepted).
    assign w_shifted = r_shadow >> {r_which, 2'b00};
    assign w_nib     = w_shifted[3:0];
    assign w_blank   = blank_lz && (r_which != 3'd0) && (w_shifted == 32'd0);

    // NOTE: each always_comb output gets a default first, so no path through
    // the case can leave it unassigned and infer a latch.
    always_comb begin
        w_glyph = 7'h7F;
        unique case (w_nib)
            4'h0: w_glyph = 7'h40;
            4'h1: w_glyph = 7'h79;
            4'h2: w_glyph = 7'h24;
            4'h3: w_glyph = 7'h30;
            4'h4: w_glyph = 7'h19;
            4'h5: w_glyph = 7'h12;
            4'h6: w_glyph = 7'h02;
            4'h7: w_glyph = 7'h78;
            4'h8: w_glyph = 7'h00;
            4'h9: w_glyph = 7'h10;
            4'hA: w_glyph = 7'h08;
            4'hB: w_glyph = 7'h03;
            4'hC: w_glyph = 7'h46;
            4'hD: w_glyph = 7'h21;
            4'hE: w_glyph = 7'h06;
            4'hF: w_glyph = 7'h0E;
            default: w_glyph = 7'h7F;
        endcase
    end

    // Priority: lamp test, then blanking, then glyph with dp.
    always_comb begin
        w_seg_next = {~dp_mask[r_which], w_glyph};
        if (all8) begin
            w_seg_next = 8'h00;
        end else if (w_blank) begin
            w_seg_next = 8'hFF;
        end
    end

    // Segment register trails which by one cycle.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_seg <= 8'hFF;
        end else begin
            r_seg <= w_seg_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [31:0] data = '0;
    logic        load = 1'b0;
    logic        all8 = 1'b0;
    logic        blank_lz = 1'b0;
    logic [7:0]  dp_mask = '0;
    logic [2:0]  which;
    logic [7:0]  seg;
    logic        upd_ack;
    logic        frame;

    int n_vec  = 0;
    int n_miss = 0;

    seg_scan_driver #(.SCAN_DIV(4)) dut (
        .clk      (clk),
        .Rst_n    (Rst_n),
        .data     (data),
        .load     (load),
        .all8     (all8),
        .blank_lz (blank_lz),
        .dp_mask  (dp_mask),
        .which    (which),
        .seg      (seg),
        .upd_ack  (upd_ack),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    // exp holds digit 7 in the top byte down to digit 0 in the bottom byte.
    typedef struct {
        logic [31:0] data;
        logic        blank_lz;
        logic        all8;
        logic [7:0]  dp_mask;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns on the negedge inside the next frame-boundary cycle.
    task automatic wait_frame(input string tag);
        int n = 0;
        @(negedge clk);
        while (!frame && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!frame) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s frame timeout: got no frame expected frame within 100 cycles", tag);
        end
    endtask

    // Called on the boundary negedge; samples every digit of the next frame.
    task automatic read_frame(input logic [63:0] exp, input string tag);
        step(2);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step(4);
            check($sformatf("%s seg d%0d", tag, k), {24'd0, seg}, {24'd0, exp[k*8 +: 8]});
            check($sformatf("%s which d%0d", tag, k), {29'd0, which}, k);
        end
    endtask

    initial begin
        vecs[0] = '{32'h1234ABCD, 1'b0, 1'b0, 8'h00, 64'hF9_A4_B0_99_88_83_C6_A1};
        vecs[1] = '{32'h00000050, 1'b1, 1'b0, 8'h00, 64'hFF_FF_FF_FF_FF_FF_92_C0};
        vecs[2] = '{32'h00000000, 1'b1, 1'b0, 8'h00, 64'hFF_FF_FF_FF_FF_FF_FF_C0};
        vecs[3] = '{32'h00000000, 1'b0, 1'b1, 8'h00, 64'h00_00_00_00_00_00_00_00};
        vecs[4] = '{32'h00000000, 1'b0, 1'b0, 8'h01, 64'hC0_C0_C0_C0_C0_C0_C0_40};
        vecs[5] = '{32'h89ABCDEF, 1'b0, 1'b0, 8'h80, 64'h00_90_88_83_C6_A1_86_8E};
        vecs[6] = '{32'h00000705, 1'b1, 1'b0, 8'h0A, 64'hFF_FF_FF_FF_FF_F8_40_92};
        vecs[7] = '{32'h00000001, 1'b1, 1'b1, 8'hFF, 64'h00_00_00_00_00_00_00_00};

        // Reset values while Rst_n is held low.
        #12;
        check("rst which", {29'd0, which}, 0);
        check("rst seg", {24'd0, seg}, 32'hFF);
        check("rst upd_ack", {31'd0, upd_ack}, 0);
        check("rst frame", {31'd0, frame}, 0);
        @(negedge clk);
        Rst_n = 1'b1;
        @(negedge clk);
        check("first seg after reset", {24'd0, seg}, 32'hC0);

        // Table: load mid-frame, expect one upd_ack with frame, then the glyphs.
        for (int v = 0; v < 8; v++) begin
            blank_lz = vecs[v].blank_lz;
            all8     = vecs[v].all8;
            dp_mask  = vecs[v].dp_mask;
            wait_frame($sformatf("v%0d sync", v));
            step(10);
            data = vecs[v].data;
            load = 1'b1;
            step(1);
            load = 1'b0;
            check($sformatf("v%0d no early ack", v), {31'd0, upd_ack}, 0);
            wait_frame($sformatf("v%0d", v));
            check($sformatf("v%0d upd_ack", v), {31'd0, upd_ack}, 1);
            read_frame(vecs[v].exp, $sformatf("v%0d", v));
        end

        // Two loads inside one frame: newest wins, single acknowledge.
        blank_lz = 1'b0;
        all8     = 1'b0;
        dp_mask  = 8'h00;
        wait_frame("dbl sync");
        step(5);
        data = 32'h11111111;
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(3);
        data = 32'h22222222;
        load = 1'b1;
        step(1);
        load = 1'b0;
        wait_frame("dbl");
        check("dbl upd_ack", {31'd0, upd_ack}, 1);
        read_frame(64'hA4_A4_A4_A4_A4_A4_A4_A4, "dbl");
        wait_frame("dbl next");
        check("dbl second ack absent", {31'd0, upd_ack}, 0);

        // Load on the boundary cycle itself: applied one frame (32 cycles) later.
        wait_frame("edge sync");
        check("edge no ack", {31'd0, upd_ack}, 0);
        data = 32'h0000CAFE;
        load = 1'b1;
        begin
            int cnt = 0;
            do begin
                @(negedge clk);
                if (cnt == 0) load = 1'b0;
                cnt++;
            end while (!frame && cnt < 100);
            check("edge ack distance", cnt, 32);
        end
        check("edge upd_ack", {31'd0, upd_ack}, 1);
        read_frame(64'hC0_C0_C0_C0_C6_88_8E_86, "edge");

        // Async reset with data pending discards it.
        wait_frame("rst2 sync");
        step(8);
        data = 32'h00005555;
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(4);
        #2 Rst_n = 1'b0;
        #1;
        check("rst2 which", {29'd0, which}, 0);
        check("rst2 seg", {24'd0, seg}, 32'hFF);
        check("rst2 upd_ack", {31'd0, upd_ack}, 0);
        check("rst2 frame", {31'd0, frame}, 0);
        step(3);
        Rst_n = 1'b1;
        @(negedge clk);
        check("rst2 first seg", {24'd0, seg}, 32'hC0);
        wait_frame("rst2");
        check("rst2 no ack", {31'd0, upd_ack}, 0);
        read_frame(64'hC0_C0_C0_C0_C0_C0_C0_C0, "rst2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, giving the clock cycles each digit is lit; legal values are 2 or more.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port data, input, 32 bits: the value to display; nibble k goes to digit k.
REQ-005 The block SHALL have port load, input, 1 bit: request to capture data; sampled on every clk edge.
REQ-006 The block SHALL have port all8, input, 1 bit: lamp test; when high, every digit shows all segments plus dp lit.
REQ-007 The block SHALL have port blank_lz, input, 1 bit: enables leading-zero blanking.
REQ-008 The block SHALL have port dp_mask, input, 8 bits: bit k lights the dp of digit k.
REQ-009 The block SHALL have port which, output, 3 bits: index of the active digit.
REQ-010 The block SHALL have port seg, output, 8 bits, active-low: seg[7] is dp, seg[6:0] are segments g..a.
REQ-011 The block SHALL have port upd_ack, output, 1 bit: one-cycle pulse when captured data becomes visible.
REQ-012 The block SHALL have port frame, output, 1 bit: one-cycle pulse at each 7-to-0 digit wrap.

Function
REQ-013 The block SHALL have a scan counter that runs from 0 to SCAN_DIV-1; its terminal-count cycle is the cycle with count equal to SCAN_DIV-1.
REQ-014 At each terminal-count edge, which SHALL advance by 1, wrapping from 7 to 0.
REQ-015 The terminal-count cycle with which equal to 7 SHALL be the frame boundary; frame SHALL be high for exactly that cycle.
REQ-016 When load is high, the block SHALL copy data into a pending register and set a pending flag.
REQ-017 A load while the pending flag is already set SHALL overwrite the pending data; only the newest value is kept, and only one upd_ack results.
REQ-018 At a frame boundary with the pending flag set, the block SHALL copy the pending data into the shadow register, clear the flag and pulse upd_ack in that same cycle.
REQ-019 At a frame boundary with the pending flag clear, the shadow register SHALL be unchanged and upd_ack SHALL stay low.
REQ-020 A load in the same cycle as a frame boundary SHALL go to the pending register and flag and be applied at the next boundary; the transfer in that cycle uses the pending contents from before the edge.
REQ-021 Displayed content SHALL only change at frame boundaries; no frame ever mixes old and new data.
REQ-022 seg SHALL be registered and, one cycle after which changes, SHALL show the glyph for shadow nibble [4k+3:4k], where k is the current which.
REQ-023 Hex glyphs with dp off SHALL be: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
REQ-024 When dp_mask[k] is 1, seg[7] SHALL be 0 for digit k.
REQ-025 When blank_lz is 1, every digit above the highest non-zero nibble of shadow SHALL show FF, including its dp.
REQ-026 Digit 0 SHALL never be blanked, so a shadow value of 0 shows a single "0".
REQ-027 When all8 is 1, seg SHALL be 00 for every digit; this overrides blanking and dp_mask.
REQ-028 all8, blank_lz and dp_mask SHALL be sampled every cycle, take effect on the next seg update, and not wait for a frame boundary.
REQ-029 Scanning SHALL run continuously; no input stalls it.

Reset
REQ-030 While Rst_n is 0, the block SHALL immediately set which=0, seg=FF, upd_ack=0, frame=0, scan counter=0, shadow=0, pending=0 and pending flag=0, independent of clk.
REQ-031 A reset in the middle of a frame or while data is pending SHALL discard the pending data; no upd_ack follows.
REQ-032 After Rst_n rises, the first seg update SHALL show C0 on digit 0, or FF on digits 1-7 when blank_lz=1 and shadow=0.

Verification (SCAN_DIV=4, so one frame is 32 cycles)
REQ-033 Load 0x1234ABCD in the middle of a frame -> shadow is unchanged until the next boundary, where upd_ack and frame pulse together; the next frame shows digits 0..7 = A1,C6,83,88,99,B0,A4,F9.
REQ-034 Loads of 0x11111111 and then 0x22222222 within one frame -> one upd_ack; the next frame shows all A4.
REQ-035 blank_lz=1 with shadow=0x00000050 -> digit 0 = C0, digit 1 = 92, digits 2-7 = FF; shadow=0 -> digit 0 = C0, others FF.
REQ-036 all8=1 with dp_mask=0 -> seg=00 on all eight digits; all8=0 with dp_mask=0x01 and shadow=0 -> digit 0 = 40.
REQ-037 Load a value, then pulse Rst_n low asynchronously before the boundary -> outputs take reset values at once; the next boundary gives no upd_ack and digit 0 shows C0.
REQ-038 Load asserted exactly on the boundary cycle with the pending flag clear -> no upd_ack at that boundary; upd_ack at the next boundary, 32 cycles later.
